// File: rtl/fifo_burst_writer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_writer
// Purpose  : Captures one frame of pixels into the FIFO, flagging each burst.
// Revision : 1.0
// ============================================================================
module fifo_burst_writer #(
    parameter int DATA_W       = 16,
    parameter int BURST_LEN    = 256,
    parameter int FRAME_BURSTS = 64,
    parameter int CNT_W        = 8,
    parameter int FCNT_W       = 6
) (
    input  logic              fifo_wr_clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic              burst_flag,
    output logic              frame_done,
    output logic              overflow,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [CNT_W-1:0]  C_LAST_WORD  = CNT_W'(BURST_LEN - 1);
    localparam logic [FCNT_W-1:0] C_LAST_BURST = FCNT_W'(FRAME_BURSTS - 1);

    logic [1:0]        state_q,      state_d;
    logic              wr_en_q,      wr_en_d;
    logic [DATA_W-1:0] din_q,        din_d;
    logic              burst_flag_q, burst_flag_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q,   overflow_d;
    logic [CNT_W-1:0]  word_cnt_q,   word_cnt_d;
    logic [FCNT_W-1:0] burst_cnt_q,  burst_cnt_d;

    always_comb begin
        state_d      = state_q;
        wr_en_d      = 1'b0;
        din_d        = din_q;
        burst_flag_d = 1'b0;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        word_cnt_d   = word_cnt_q;
        burst_cnt_d  = burst_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d     = ST_CAPTURE;
                    word_cnt_d  = '0;
                    burst_cnt_d = '0;
                    overflow_d  = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (pix_valid && fifo_full) begin
                    overflow_d = 1'b1;
                end else if (pix_valid) begin
                    wr_en_d = 1'b1;
                    din_d   = pix_data;
                    if (word_cnt_q == C_LAST_WORD) begin
                        word_cnt_d   = '0;
                        burst_flag_d = 1'b1;
                        // Final burst: counter wraps so it never exceeds its width.
                        if (burst_cnt_q == C_LAST_BURST) begin
                            burst_cnt_d  = '0;
                            frame_done_d = 1'b1;
                            state_d      = ST_DONE;
                        end else begin
                            burst_cnt_d = burst_cnt_q + FCNT_W'(1);
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge fifo_wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_en_q      <= 1'b0;
            din_q        <= '0;
            burst_flag_q <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            word_cnt_q   <= '0;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            din_q        <= din_d;
            burst_flag_q <= burst_flag_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            word_cnt_q   <= word_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    assign fifo_wr_en = wr_en_q;
    assign fifo_din   = din_q;
    assign burst_flag = burst_flag_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q == ST_CAPTURE);
    assign word_cnt   = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_writer
// Purpose  : Directed stimulus with a frame-level reference model and checks.
// Revision : 1.0
// ============================================================================
module tb_fifo_burst_writer;

    localparam int C_DW = 16;
    localparam int C_BL = 4;
    localparam int C_FB = 2;
    localparam int C_CW = 2;
    localparam int C_FW = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            frame_start = 1'b0;
    logic            pix_valid = 1'b0;
    logic [C_DW-1:0] pix_data = '0;
    logic            fifo_full = 1'b0;
    logic            fifo_wr_en;
    logic [C_DW-1:0] fifo_din;
    logic            burst_flag;
    logic            frame_done;
    logic            overflow;
    logic            busy;
    logic [C_CW-1:0] word_cnt;

    int total = 0;
    int bad   = 0;

    fifo_burst_writer #(
        .DATA_W(C_DW), .BURST_LEN(C_BL), .FRAME_BURSTS(C_FB),
        .CNT_W(C_CW), .FCNT_W(C_FW)
    ) dut (
        .fifo_wr_clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_data(pix_data), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .burst_flag(burst_flag),
        .frame_done(frame_done), .overflow(overflow), .busy(busy),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 capturing, 2 one-cycle cool-down.
    int            m_phase = 0;
    int            m_acc   = 0;
    bit            m_ovf   = 1'b0;
    bit            e_wr    = 1'b0;
    bit            e_bf    = 1'b0;
    bit            e_fd    = 1'b0;
    logic [C_DW-1:0] e_din = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_acc <= 0; m_ovf <= 1'b0;
            e_wr <= 1'b0; e_bf <= 1'b0; e_fd <= 1'b0; e_din <= '0;
        end else begin
            e_wr <= 1'b0; e_bf <= 1'b0; e_fd <= 1'b0;
            if (m_phase == 0) begin
                if (frame_start) begin
                    m_phase <= 1; m_acc <= 0; m_ovf <= 1'b0;
                end
            end else if (m_phase == 2) begin
                m_phase <= 0;
            end else if (pix_valid) begin
                if (fifo_full) begin
                    m_ovf <= 1'b1;
                end else begin
                    e_wr  <= 1'b1;
                    e_din <= pix_data;
                    m_acc <= m_acc + 1;
                    if ((m_acc + 1) % C_BL == 0) e_bf <= 1'b1;
                    if (m_acc + 1 == C_BL * C_FB) begin
                        e_fd <= 1'b1;
                        m_phase <= 2;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("wr_en",      32'(fifo_wr_en), 32'(e_wr));
        chk("din",        32'(fifo_din),   32'(e_din));
        chk("burst_flag", 32'(burst_flag), 32'(e_bf));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("busy",       32'(busy),       32'(m_phase == 1));
        chk("word_cnt",   32'(word_cnt),   32'(m_acc % C_BL));
    end

    logic [C_DW-1:0] wq[$];
    int nbf = 0;
    int nfd = 0;

    always @(negedge clk) begin
        if (fifo_wr_en) wq.push_back(fifo_din);
        if (burst_flag) nbf++;
        if (frame_done) nfd++;
    end

    task automatic cyc(input logic fs, input logic pv, input logic [C_DW-1:0] pd,
                       input logic full);
        frame_start = fs; pix_valid = pv; pix_data = pd; fifo_full = full;
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        wq.delete(); nbf = 0; nfd = 0;
    endtask

    task automatic chk_writes(input string nm, input logic [C_DW-1:0] first);
        chk({nm, "_count"}, 32'(wq.size()), 32'(8));
        for (int i = 0; i < wq.size() && i < 8; i++)
            chk({nm, "_data"}, 32'(wq[i]), 32'(first + C_DW'(i)));
    endtask

    initial begin
        // Reset, then pix_valid without frame_start must do nothing.
        repeat (3) cyc(0, 0, '0, 0);
        rst_n = 1'b1;
        clr();
        for (int i = 0; i < 10; i++) cyc(0, 1, C_DW'(16'h00A0 + i), 0);
        chk("idle_writes", 32'(wq.size()), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_wc", 32'(word_cnt), 32'(0));

        // Full-rate frame of eight words, plus a ninth that must be ignored.
        clr();
        cyc(1, 0, '0, 0);
        for (int i = 1; i <= 9; i++) cyc(0, 1, C_DW'(i), 0);
        repeat (3) cyc(0, 0, '0, 0);
        chk_writes("f1", 16'h0001);
        chk("f1_bursts", 32'(nbf), 32'(2));
        chk("f1_frames", 32'(nfd), 32'(1));
        chk("f1_busy_after", 32'(busy), 32'(0));

        // One dropped sample while full; overflow sticks until next frame_start.
        clr();
        cyc(1, 0, '0, 0);
        cyc(0, 1, 16'h0011, 0);
        cyc(0, 1, 16'h0012, 0);
        cyc(0, 1, 16'h00EE, 1);
        for (int i = 3; i <= 8; i++) cyc(0, 1, C_DW'(16'h0010 + i), 0);
        repeat (3) cyc(0, 0, '0, 0);
        chk_writes("f2", 16'h0011);
        chk("f2_ovf_held", 32'(overflow), 32'(1));
        cyc(1, 0, '0, 0);
        chk("f2_ovf_clear", 32'(overflow), 32'(0));

        // Gapped input within the new frame.
        cyc(0, 1, 16'h0021, 0); chk("gap_wc1", 32'(word_cnt), 32'(1));
        cyc(0, 0, 16'h0099, 0); chk("gap_hold1", 32'(word_cnt), 32'(1));
        chk("gap_no_wr", 32'(fifo_wr_en), 32'(0));
        cyc(0, 1, 16'h0022, 0); chk("gap_wc2", 32'(word_cnt), 32'(2));
        cyc(0, 0, 16'h0099, 0);
        cyc(0, 1, 16'h0023, 0); chk("gap_wc3", 32'(word_cnt), 32'(3));
        cyc(0, 0, 16'h0099, 0);
        cyc(0, 1, 16'h0024, 0); chk("gap_wc_wrap", 32'(word_cnt), 32'(0));
        chk("gap_bf", 32'(burst_flag), 32'(1));
        cyc(0, 0, '0, 0);
        chk("gap_bf_once", 32'(burst_flag), 32'(0));

        // Asynchronous reset mid-frame after five samples.
        cyc(0, 0, '0, 0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        cyc(1, 0, '0, 0);
        for (int i = 1; i <= 5; i++) cyc(0, 1, C_DW'(16'h0030 + i), 0);
        pix_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr", 32'(fifo_wr_en), 32'(0));
        chk("arst_din", 32'(fifo_din), 32'(0));
        chk("arst_wc", 32'(word_cnt), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc(1, 0, '0, 0);
        cyc(0, 1, 16'h0041, 0);
        cyc(0, 1, 16'h0042, 0);
        cyc(0, 1, 16'h0043, 0);
        chk("rs_wc3", 32'(word_cnt), 32'(3));
        chk("rs_bf_early", 32'(burst_flag), 32'(0));
        cyc(0, 1, 16'h0044, 0);
        chk("rs_bf", 32'(burst_flag), 32'(1));
        chk("rs_wc0", 32'(word_cnt), 32'(0));

        // frame_start during capture and during DONE is ignored.
        cyc(0, 1, 16'h0051, 0);
        cyc(0, 1, 16'h0052, 0);
        cyc(0, 1, 16'h0053, 0);
        cyc(1, 0, '0, 0);
        chk("mid_fs_wc", 32'(word_cnt), 32'(3));
        cyc(0, 1, 16'h0054, 0);
        chk("mid_fs_bf", 32'(burst_flag), 32'(1));
        chk("mid_fs_fd", 32'(frame_done), 32'(1));
        chk("mid_fs_din", 32'(fifo_din), 32'(16'h0054));
        cyc(1, 0, '0, 0);
        cyc(0, 0, '0, 0);
        chk("done_fs_ignored", 32'(busy), 32'(0));
        repeat (3) cyc(0, 0, '0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
